// File: rtl/flash_loader.sv
// Boot-time copier: reads bytes from an 8-bit parallel flash, packs them into
// big-endian 32-bit words and writes each word to main memory via req/ack.
module flash_loader #(
  parameter int WORD_COUNT = 32768,
  parameter int FL_WAIT    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [21:0] FL_ADDR,
  input  logic [7:0]  FL_DQ,
  output logic        FL_CE_N,
  output logic        FL_OE_N,
  output logic        FL_WE_N,
  output logic        FL_RST_N,
  output logic [19:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        mem_wr,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [3:0]  WAIT_LOAD = 4'(FL_WAIT);
  localparam logic [19:0] LAST_WORD = 20'(WORD_COUNT - 1);

  state_t      state;
  logic [3:0]  wait_cnt;
  // Only the first three bytes need holding; byte 3 goes straight into mem_data.
  logic [23:0] word;

  assign FL_WE_N  = 1'b1;
  assign FL_RST_N = ~reset;

  // NOTE: all state is updated with non-blocking assignments so every branch
  // below reads the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      word     <= '0;
      FL_ADDR  <= '0;
      mem_addr <= '0;
      mem_data <= '0;
      mem_wr   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      FL_CE_N  <= 1'b1;
      FL_OE_N  <= 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            FL_ADDR  <= '0;
            wait_cnt <= WAIT_LOAD;
            busy     <= 1'b1;
            done     <= 1'b0;
            FL_CE_N  <= 1'b0;
            FL_OE_N  <= 1'b0;
            state    <= READ;
          end
        end

        READ: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            word <= {word[15:0], FL_DQ};
            if (FL_ADDR[1:0] != 2'd3) begin
              FL_ADDR  <= FL_ADDR + 22'd1;
              wait_cnt <= WAIT_LOAD;
            end else begin
              mem_wr   <= 1'b1;
              mem_data <= {word, FL_DQ};
              mem_addr <= FL_ADDR[21:2];
              state    <= WRITE;
            end
          end
        end

        WRITE: begin
          if (mem_ack) begin
            mem_wr <= 1'b0;
            if (mem_addr == LAST_WORD) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              FL_CE_N <= 1'b1;
              FL_OE_N <= 1'b1;
              state   <= DONE;
            end else begin
              FL_ADDR  <= FL_ADDR + 22'd1;
              wait_cnt <= WAIT_LOAD;
              state    <= READ;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
